// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: the head entry is always on rdata while non-empty.
// Zero-latency pop; writes are dropped while full and pops are ignored while empty.
module sync_fifo_fwft #(
    parameter int DSIZE   = 64,
    parameter int ASIZE   = 5,
    parameter int MEMSIZE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wval,
    input  logic [DSIZE-1:0] wdata,
    output logic             full,
    input  logic             ren,
    output logic [DSIZE-1:0] rdata,
    output logic             empty
);

    logic [ASIZE-1:0] r_wptr;
    logic [ASIZE-1:0] r_rptr;
    logic [DSIZE-1:0] r_mem [MEMSIZE];

    logic             w_wr_en;
    logic             w_rd_en;

    // The extra wrap bit separates full from empty when the index bits match.
    assign empty   = (r_wptr == r_rptr);
    assign full    = (r_wptr[ASIZE-1] != r_rptr[ASIZE-1]) &&
                     (r_wptr[ASIZE-2:0] == r_rptr[ASIZE-2:0]);
    assign w_wr_en = wval && !full;
    assign w_rd_en = ren && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_en) r_wptr <= r_wptr + 1'b1;
            if (w_rd_en) r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage is deliberately left unreset; consumers qualify rdata with !empty.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wptr[ASIZE-2:0]] <= wdata;
    end

    assign rdata = r_mem[r_rptr[ASIZE-2:0]];

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed plus randomized bench for sync_fifo_fwft against a queue reference model.
module tb_sync_fifo_fwft;

    localparam int DEPTH = 16;

    logic        clk;
    logic        reset;
    logic        wval;
    logic [63:0] wdata;
    logic        full;
    logic        ren;
    logic [63:0] rdata;
    logic        empty;

    logic [63:0] q[$];
    int          n_cmp;
    int          n_err;

    sync_fifo_fwft #(.DSIZE(64), .ASIZE(5), .MEMSIZE(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .wval  (wval),
        .wdata (wdata),
        .full  (full),
        .ren   (ren),
        .rdata (rdata),
        .empty (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_empty"}, {63'd0, empty}, {63'd0, q.size() == 0});
        chk({tag, "_full"},  {63'd0, full},  {63'd0, q.size() == DEPTH});
        if (q.size() > 0) chk({tag, "_rdata"}, rdata, q[0]);
    endtask

    // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
    task automatic cyc(input logic wv, input logic [63:0] wd, input logic rv, input string tag);
        bit acc_w, acc_r;
        wval  = wv;
        wdata = wd;
        ren   = rv;
        acc_w = wv && (q.size() != DEPTH);
        acc_r = rv && (q.size() != 0);
        @(posedge clk);
        if (acc_r) void'(q.pop_front());
        if (acc_w) q.push_back(wd);
        #1;
        wval = 1'b0;
        ren  = 1'b0;
        chk_model(tag);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        wval  = 1'b0;
        ren   = 1'b0;
        wdata = '0;
        reset = 1'b0;

        // Reset asserted between edges must clear flags immediately.
        #2 reset = 1'b1;
        #1;
        chk("reset_empty", {63'd0, empty}, 64'd1);
        chk("reset_full",  {63'd0, full},  64'd0);
        #10 reset = 1'b0;
        @(posedge clk); #1;
        cyc(1'b0, 64'd0, 1'b1, "ren_on_empty");

        // Single write then FWFT read.
        cyc(1'b1, 64'hDEADBEEF_00000001, 1'b0, "single_wr");
        chk("fwft_rdata", rdata, 64'hDEADBEEF_00000001);
        chk("fwft_nonempty", {63'd0, empty}, 64'd0);
        cyc(1'b0, 64'd0, 1'b1, "single_rd");
        chk("single_rd_empty", {63'd0, empty}, 64'd1);

        // Fill to full, attempt overflow, drain in order.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 64'(i), 1'b0, "fill");
        chk("fill_full", {63'd0, full}, 64'd1);
        cyc(1'b1, 64'hFF, 1'b0, "overflow");
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_seq", rdata, 64'(i));
            cyc(1'b0, 64'd0, 1'b1, "drain");
        end
        chk("drain_empty", {63'd0, empty}, 64'd1);

        // Simultaneous write and read at half occupancy.
        for (int i = 0; i < 8; i++) cyc(1'b1, rnd64(), 1'b0, "half_fill");
        for (int i = 0; i < 10; i++) cyc(1'b1, rnd64(), 1'b1, "half_simul");
        while (q.size() > 0) cyc(1'b0, 64'd0, 1'b1, "half_drain");

        // Simultaneous on empty: only the write lands.
        cyc(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, "empty_simul");
        chk("empty_simul_rdata", rdata, 64'h1234_5678_9ABC_DEF0);
        cyc(1'b0, 64'd0, 1'b1, "empty_simul_drain");

        // Simultaneous on full: only the read occurs.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 64'(100 + i), 1'b0, "full_fill");
        cyc(1'b1, 64'hBAD, 1'b1, "full_simul");
        chk("full_simul_full", {63'd0, full}, 64'd0);
        chk("full_simul_head", rdata, 64'd101);
        while (q.size() > 0) cyc(1'b0, 64'd0, 1'b1, "full_drain");

        // Streaming across pointer wrap at occupancy 3.
        for (int i = 0; i < 3; i++) cyc(1'b1, rnd64(), 1'b0, "wrap_pre");
        for (int i = 0; i < 40; i++) cyc(1'b1, rnd64(), 1'b1, "wrap_stream");
        while (q.size() > 0) cyc(1'b0, 64'd0, 1'b1, "wrap_drain");

        // Random traffic with biased write/read probabilities.
        for (int i = 0; i < 400; i++) begin
            int unsigned wp;
            wp = (i < 200) ? 70 : 30;
            cyc($urandom_range(99) < wp, rnd64(), $urandom_range(99) < 50, "random");
        end

        // Reset mid-operation discards held entries.
        while (q.size() > 0) cyc(1'b0, 64'd0, 1'b1, "pre_rst_drain");
        for (int i = 0; i < 5; i++) cyc(1'b1, 64'(200 + i), 1'b0, "pre_rst_fill");
        #2 reset = 1'b1;
        #1;
        q.delete();
        chk("midrst_empty", {63'd0, empty}, 64'd1);
        chk("midrst_full",  {63'd0, full},  64'd0);
        #3 reset = 1'b0;
        cyc(1'b1, 64'hA5, 1'b0, "post_rst_wr");
        chk("post_rst_rdata", rdata, 64'hA5);
        cyc(1'b0, 64'd0, 1'b1, "post_rst_rd");
        chk("post_rst_empty", {63'd0, empty}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
